// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT constants, sample word type and address bit-reversal
package fft_pkg;
  localparam int FFT_N_LOG2 = 4;
  localparam int FFT_DW = 16;
  typedef struct packed {
    logic [FFT_DW-1:0] re;
    logic [FFT_DW-1:0] im;
  } fft_sample_t;
  typedef enum logic {IDLE, RUN} fft_unload_state_t;
  function automatic logic [15:0] bitrev(input logic [15:0] k, input int n_log2);
    logic [15:0] r;
    logic [15:0] x;
    r = '0;
    x = k;
    for (int i = 0; i < 16; i++)
      if (i < n_log2) begin
        r = {r[14:0], x[0]};
        x = x >> 1;
      end
    return r;
  endfunction
endpackage

// File: rtl/fft_output_unload_if.sv
// fft_output_unload_if: result RAM read port plus the downstream bin stream
interface fft_output_unload_if import fft_pkg::*; #(
  parameter int N_LOG2 = FFT_N_LOG2,
  parameter int DW = FFT_DW
);
  logic              rd_en_o;
  logic [N_LOG2-1:0] rd_addr_o;
  logic [DW-1:0]     rd_re_i;
  logic [DW-1:0]     rd_im_i;
  logic              valid_o;
  logic              ready_o;
  logic [DW-1:0]     re_o;
  logic [DW-1:0]     im_o;
  logic [N_LOG2-1:0] idx_o;
  logic              last_o;
  modport master (
    output rd_en_o, rd_addr_o, valid_o, re_o, im_o, idx_o, last_o,
    input  rd_re_i, rd_im_i, ready_o
  );
  modport slave (
    input  rd_en_o, rd_addr_o, valid_o, re_o, im_o, idx_o, last_o,
    output rd_re_i, rd_im_i, ready_o
  );
endinterface

// File: rtl/fft_out_fifo2.sv
// fft_out_fifo2: 2-entry FIFO of {idx, re, im} decoupling RAM latency from backpressure
module fft_out_fifo2 #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wp;
  logic rp;
  // storage, pointers and occupancy; push and pop together leave count unchanged
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + 2'(push) - 2'(pop);
    end
  assign head = mem[rp];
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && !pop && count == 2'd2));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(pop && count == 2'd0));
endmodule

// File: rtl/fft_output_unload.sv
// fft_output_unload: reads FFT results in bit-reversed RAM order and streams bins in natural order
module fft_output_unload import fft_pkg::*; #(
  parameter int N_LOG2 = FFT_N_LOG2,
  parameter int DW = FFT_DW,
  parameter bit BITREV = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic done_i,
  output logic busy_o,
  output logic overrun_o,
  fft_output_unload_if.master bus
);
  localparam int W = N_LOG2 + 2 * DW;
  localparam int N = 2 ** N_LOG2;
  fft_unload_state_t state_q, state_d;
  logic [N_LOG2:0]   rd_k_q;
  logic              inflight_q;
  logic [N_LOG2-1:0] inflight_idx_q;
  logic [1:0]        count;
  logic [W-1:0]      head;
  logic [N_LOG2-1:0] idx;
  logic [N_LOG2-1:0] addr;
  logic [2:0]        occ;
  logic              valid;
  logic              pop;
  logic              fin;
  logic              start;
  logic              rd_en;
  fft_out_fifo2 #(.W(W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(inflight_q),
    .pop(pop),
    .din({inflight_idx_q, bus.rd_re_i, bus.rd_im_i}),
    .head(head),
    .count(count)
  );
  assign idx = head[W-1 -: N_LOG2];
  assign valid = count != 2'd0;
  assign pop = valid & bus.ready_o;
  assign fin = pop & (idx == N_LOG2'(N - 1));
  assign {bus.idx_o, bus.re_o, bus.im_o} = head;
  assign bus.valid_o = valid;
  assign bus.last_o = valid & (idx == N_LOG2'(N - 1));
  assign bus.rd_en_o = rd_en;
  assign bus.rd_addr_o = rd_en ? addr : '0;
  assign busy_o = state_q == RUN;
  // next state and read issue: a read may go out only if the FIFO can still absorb it
  // after this cycle's pop, counting the read already on its way back from the RAM
  always_comb begin
    start = done_i & (state_q == IDLE | fin);
    state_d = start ? RUN : fin ? IDLE : state_q;
    occ = 3'(count) + 3'(inflight_q);
    rd_en = (state_q == RUN) & !rd_k_q[N_LOG2] & (occ < 3'd2 + 3'(pop));
    addr = BITREV ? N_LOG2'(bitrev(16'(rd_k_q[N_LOG2-1:0]), N_LOG2)) : rd_k_q[N_LOG2-1:0];
  end
  // state, saturating issue counter, return tag and overrun pulse
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      rd_k_q <= '0;
      inflight_q <= 1'b0;
      inflight_idx_q <= '0;
      overrun_o <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_k_q <= start ? '0 : rd_k_q + {{N_LOG2{1'b0}}, rd_en};
      inflight_q <= rd_en;
      inflight_idx_q <= rd_k_q[N_LOG2-1:0];
      overrun_o <= done_i & (state_q == RUN) & !fin;
    end
endmodule

// File: tb/tb_fft_output_unload.sv
// tb_fft_output_unload: randomized scenario bench against a frame-level reference model
module tb_fft_output_unload;
  import fft_pkg::*;
  localparam int NL = 4;
  localparam int N = 16;
  localparam int DW = 16;
  typedef struct {
    int idx;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic last;
    int cyc;
  } xfer_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic done = 1'b0;
  logic ready = 1'b0;
  logic busy0, ovr0, busy1, ovr1;
  logic [DW-1:0] re_mem [N];
  logic [DW-1:0] im_mem [N];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  xfer_t cap0[$];
  xfer_t cap1[$];
  int issued = 0, nx = 0, max_ahead = 0, ovr_cnt = 0, busy_falls = 0, stall_viol = 0;
  logic pv = 1'b0, pr = 1'b0, pbusy = 1'b0;
  logic [NL-1:0] pidx = '0;
  logic [DW-1:0] pre = '0, pim = '0;

  fft_output_unload_if #(.N_LOG2(NL), .DW(DW)) b0 ();
  fft_output_unload_if #(.N_LOG2(NL), .DW(DW)) b1 ();
  fft_output_unload #(.N_LOG2(NL), .DW(DW), .BITREV(1'b1)) dut0 (
    .clk(clk), .rst(rst), .done_i(done), .busy_o(busy0), .overrun_o(ovr0), .bus(b0));
  fft_output_unload #(.N_LOG2(NL), .DW(DW), .BITREV(1'b0)) dut1 (
    .clk(clk), .rst(rst), .done_i(done), .busy_o(busy1), .overrun_o(ovr1), .bus(b1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign b0.ready_o = ready;
  assign b1.ready_o = ready;
  // result RAMs with one cycle read latency
  always @(posedge clk) if (b0.rd_en_o) begin
    b0.rd_re_i <= re_mem[b0.rd_addr_o];
    b0.rd_im_i <= im_mem[b0.rd_addr_o];
  end
  always @(posedge clk) if (b1.rd_en_o) begin
    b1.rd_re_i <= re_mem[b1.rd_addr_o];
    b1.rd_im_i <= im_mem[b1.rd_addr_o];
  end
  // transfer capture and protocol observation, sampled mid-cycle
  always @(negedge clk)
    if (!rst) begin
      issued <= 0;
      nx <= 0;
      pv <= 1'b0;
      pbusy <= 1'b0;
    end else begin
      if (pv && !pr && (b0.valid_o !== 1'b1 || b0.idx_o !== pidx || b0.re_o !== pre || b0.im_o !== pim))
        stall_viol <= stall_viol + 1;
      if (ovr0) ovr_cnt <= ovr_cnt + 1;
      if (pbusy && !busy0) busy_falls <= busy_falls + 1;
      if (issued - nx + int'(b0.rd_en_o) - int'(b0.valid_o & ready) > max_ahead)
        max_ahead <= issued - nx + int'(b0.rd_en_o) - int'(b0.valid_o & ready);
      issued <= issued + int'(b0.rd_en_o);
      if (b0.valid_o & ready) begin
        nx <= nx + 1;
        cap0.push_back('{int'(b0.idx_o), b0.re_o, b0.im_o, b0.last_o, cyc});
      end
      if (b1.valid_o & ready) cap1.push_back('{int'(b1.idx_o), b1.re_o, b1.im_o, b1.last_o, cyc});
      pv <= b0.valid_o;
      pr <= ready;
      pidx <= b0.idx_o;
      pre <= b0.re_o;
      pim <= b0.im_o;
      pbusy <= busy0;
    end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int rev(int k);
    int r = 0;
    int x = k;
    for (int i = 0; i < NL; i++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  // number of bins in a captured frame that differ from the model: bin k is RAM word
  // at rev(k) (or k), carries idx k, and is flagged last only for k = N-1
  function automatic int bad_bins(int base, bit nat);
    int e = 0;
    int a;
    xfer_t x;
    for (int k = 0; k < N; k++) begin
      if (base + k >= (nat ? cap1.size() : cap0.size())) e++;
      else begin
        x = nat ? cap1[base + k] : cap0[base + k];
        a = nat ? k : rev(k);
        if (x.idx != k || x.re !== re_mem[a] || x.im !== im_mem[a] || x.last !== (k == N - 1)) e++;
      end
    end
    return e;
  endfunction

  function automatic int cyc_of(int i);
    return (i < cap0.size()) ? cap0[i].cyc : -1000;
  endfunction

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_done;
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  task automatic fill_random;
    for (int a = 0; a < N; a++) begin
      re_mem[a] = 16'($urandom);
      im_mem[a] = 16'($urandom);
    end
  endtask

  task automatic wait_xfers(int target, int budget, string tag);
    int t = 0;
    while (cap0.size() < target && t < budget) begin
      step();
      t++;
    end
    n_checks++;
    if (cap0.size() < target) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d transfers, required %0d", tag, cap0.size(), target);
    end
  endtask

  task automatic wait_head(int k, int budget, string tag);
    int t = 0;
    while (!(b0.valid_o === 1'b1 && int'(b0.idx_o) == k) && t < budget) begin
      step();
      t++;
    end
    n_checks++;
    if (!(b0.valid_o === 1'b1 && int'(b0.idx_o) == k)) begin
      n_fail++;
      $display("FAIL %s_head: bin %0d never reached the output, idx now %0d", tag, k, b0.idx_o);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    done = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if ({b0.valid_o, b0.rd_en_o, b0.rd_addr_o, b0.re_o, b0.im_o, b0.idx_o, b0.last_o, busy0, ovr0} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got valid=%b rd_en=%b busy=%b ovr=%b, required all 0",
                 b0.valid_o, b0.rd_en_o, busy0, ovr0);
      end
    end
    done = 1'b0;
    rst = 1'b1;
    step(3);
    n_checks++;
    if ({busy0, b0.valid_o, b0.rd_en_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: got busy/valid/rd_en=%b, required 000", {busy0, b0.valid_o, b0.rd_en_o});
    end
  endtask

  task automatic test_impulse;
    int base, dcyc;
    for (int a = 0; a < N; a++) begin
      re_mem[a] = 16'h07ff;
      im_mem[a] = 16'h0000;
    end
    ready = 1'b1;
    base = cap0.size();
    dcyc = cyc;
    pulse_done();
    wait_xfers(base + N, 40, "impulse");
    step(4);
    n_checks++;
    if (cap0.size() - base != N) begin
      n_fail++;
      $display("FAIL impulse_count: got %0d transfers, required %0d", cap0.size() - base, N);
    end
    n_checks++;
    if (bad_bins(base, 1'b0) != 0) begin
      n_fail++;
      $display("FAIL impulse_bins: got %0d bad bins, required 0", bad_bins(base, 1'b0));
    end
    n_checks++;
    if (cyc_of(base) - dcyc != 3) begin
      n_fail++;
      $display("FAIL impulse_latency: got %0d cycles, required 3", cyc_of(base) - dcyc);
    end
    n_checks++;
    if (cyc_of(base + N - 1) - cyc_of(base) != N - 1) begin
      n_fail++;
      $display("FAIL impulse_consecutive: got span %0d, required %0d", cyc_of(base + N - 1) - cyc_of(base), N - 1);
    end
    n_checks++;
    if (busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL impulse_busy_end: got %b, required 0", busy0);
    end
  endtask

  task automatic test_addr_order;
    int base0, base1;
    for (int a = 0; a < N; a++) begin
      re_mem[a] = 16'(a);
      im_mem[a] = ~16'(a);
    end
    ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      base0 = cap0.size();
      base1 = cap1.size();
      pulse_done();
      wait_xfers(base0 + N, 40, "addr");
      step(4);
      if (f == 0) begin
        n_checks++;
        if (base0 + 3 >= cap0.size() || cap0[base0 + 1].re !== 16'h8 || cap0[base0 + 3].re !== 16'hc) begin
          n_fail++;
          $display("FAIL addr_bitrev_samples: got bin1 re=%0h bin3 re=%0h, required 8 and c",
                   (base0 + 1 < cap0.size()) ? cap0[base0 + 1].re : 16'hxxxx,
                   (base0 + 3 < cap0.size()) ? cap0[base0 + 3].re : 16'hxxxx);
        end
      end
      n_checks++;
      if (bad_bins(base0, 1'b0) != 0) begin
        n_fail++;
        $display("FAIL addr_bitrev_frame%0d: got %0d bad bins, required 0", f, bad_bins(base0, 1'b0));
      end
      n_checks++;
      if (bad_bins(base1, 1'b1) != 0) begin
        n_fail++;
        $display("FAIL addr_natural_frame%0d: got %0d bad bins, required 0", f, bad_bins(base1, 1'b1));
      end
      fill_random();
    end
  endtask

  task automatic test_backpressure;
    int base, sv0, t;
    bit held;
    fill_random();
    base = cap0.size();
    sv0 = stall_viol;
    held = 1'b0;
    t = 0;
    ready = 1'($urandom);
    pulse_done();
    while (cap0.size() < base + N && t < 600) begin
      if (!held && b0.valid_o === 1'b1 && b0.idx_o == 4'd5) begin
        ready = 1'b0;
        step(10);
        held = 1'b1;
      end else begin
        ready = 1'($urandom);
        step();
      end
      t++;
    end
    ready = 1'b1;
    step(6);
    n_checks++;
    if (cap0.size() - base != N) begin
      n_fail++;
      $display("FAIL bp_count: got %0d transfers, required %0d", cap0.size() - base, N);
    end
    n_checks++;
    if (bad_bins(base, 1'b0) != 0) begin
      n_fail++;
      $display("FAIL bp_bins: got %0d bad bins, required 0", bad_bins(base, 1'b0));
    end
    n_checks++;
    if (stall_viol != sv0) begin
      n_fail++;
      $display("FAIL bp_stable: got %0d unstable stalled cycles, required 0", stall_viol - sv0);
    end
    n_checks++;
    if (max_ahead > 2) begin
      n_fail++;
      $display("FAIL bp_reads_ahead: got %0d, required at most 2", max_ahead);
    end
    n_checks++;
    if (!held) begin
      n_fail++;
      $display("FAIL bp_hold_k5: got bin 5 never held, required held for 10 cycles");
    end
  endtask

  task automatic test_overrun;
    int base, o0;
    fill_random();
    ready = 1'b1;
    base = cap0.size();
    o0 = ovr_cnt;
    pulse_done();
    wait_head(8, 40, "ovr");
    pulse_done();
    wait_xfers(base + N, 40, "ovr");
    step(4);
    n_checks++;
    if (ovr_cnt - o0 != 1) begin
      n_fail++;
      $display("FAIL ovr_pulses: got %0d, required 1", ovr_cnt - o0);
    end
    n_checks++;
    if (cap0.size() - base != N || bad_bins(base, 1'b0) != 0) begin
      n_fail++;
      $display("FAIL ovr_frame: got %0d transfers %0d bad, required %0d and 0", cap0.size() - base, bad_bins(base, 1'b0), N);
    end
    base = cap0.size();
    o0 = ovr_cnt;
    pulse_done();
    wait_head(N - 1, 40, "ovr_last");
    pulse_done();
    n_checks++;
    if ({busy0, b0.rd_en_o, b0.rd_addr_o} !== {2'b11, 4'h0}) begin
      n_fail++;
      $display("FAIL ovr_restart: got busy=%b rd_en=%b addr=%0h, required 1 1 0", busy0, b0.rd_en_o, b0.rd_addr_o);
    end
    wait_xfers(base + 2 * N, 60, "ovr_last");
    step(4);
    n_checks++;
    if (ovr_cnt != o0) begin
      n_fail++;
      $display("FAIL ovr_on_last: got %0d pulses, required 0", ovr_cnt - o0);
    end
    n_checks++;
    if (bad_bins(base + N, 1'b0) != 0) begin
      n_fail++;
      $display("FAIL ovr_next_frame: got %0d bad bins, required 0", bad_bins(base + N, 1'b0));
    end
  endtask

  task automatic test_reset_mid;
    int base, sz;
    fill_random();
    ready = 1'b1;
    base = cap0.size();
    pulse_done();
    wait_head(6, 40, "rstmid");
    rst = 1'b0;
    #1;
    n_checks++;
    if ({b0.valid_o, b0.rd_en_o, b0.rd_addr_o, b0.re_o, b0.im_o, b0.idx_o, b0.last_o, busy0, ovr0} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got valid=%b rd_en=%b idx=%0h re=%0h busy=%b, required all 0",
               b0.valid_o, b0.rd_en_o, b0.idx_o, b0.re_o, busy0);
    end
    sz = cap0.size();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step(5);
    n_checks++;
    if (sz - base != 6 || cap0.size() != sz) begin
      n_fail++;
      $display("FAIL rstmid_emitted: got %0d before and %0d after reset, required 6 and 0", sz - base, cap0.size() - sz);
    end
    n_checks++;
    if ({busy0, b0.valid_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_idle: got busy/valid=%b, required 00", {busy0, b0.valid_o});
    end
    base = cap0.size();
    pulse_done();
    wait_xfers(base + N, 40, "rstmid");
    step(4);
    n_checks++;
    if (cap0.size() - base != N || bad_bins(base, 1'b0) != 0) begin
      n_fail++;
      $display("FAIL rstmid_next_frame: got %0d transfers %0d bad, required %0d and 0", cap0.size() - base, bad_bins(base, 1'b0), N);
    end
  endtask

  task automatic test_back_to_back;
    int base, bf;
    fill_random();
    ready = 1'b1;
    base = cap0.size();
    bf = busy_falls;
    pulse_done();
    wait_head(N - 1, 40, "b2b");
    pulse_done();
    wait_xfers(base + 2 * N, 60, "b2b");
    step(4);
    n_checks++;
    if (cap0.size() - base != 2 * N) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d transfers, required %0d", cap0.size() - base, 2 * N);
    end
    n_checks++;
    if (bad_bins(base, 1'b0) + bad_bins(base + N, 1'b0) != 0) begin
      n_fail++;
      $display("FAIL b2b_bins: got %0d bad bins, required 0", bad_bins(base, 1'b0) + bad_bins(base + N, 1'b0));
    end
    n_checks++;
    if (busy_falls - bf != 1) begin
      n_fail++;
      $display("FAIL b2b_busy: got %0d busy drops, required 1", busy_falls - bf);
    end
    n_checks++;
    if (cyc_of(base + N) - cyc_of(base + N - 1) != 3) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d cycles between frames, required 3", cyc_of(base + N) - cyc_of(base + N - 1));
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_addr_order();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
